// File: rtl/freq_sweeper_multimode.sv
// DDS tuning-word controller: linear up/down/triangle sweeps and a PI phase-tracking loop.
// Optional lock detector (pll_locked, LOCK_THRESH) is built when FREQ_SWEEPER_LOCK_DETECT_EN is defined.
module freq_sweeper_multimode #(
  parameter int FTW_W       = 32,
  parameter int CYC_W       = 16,
  parameter int STEP_W      = 8,
  parameter int PHASE_W     = 16,
  parameter int KP_SHIFT    = 3,
  parameter int KI_SHIFT    = 0,
  parameter int LOCK_CYCLES = 1024,
  parameter int TRACK_DIV   = 16
`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
  ,
  parameter int LOCK_THRESH = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [1:0]         instr_mode,
  input  logic [FTW_W-1:0]   instr_init_freq,
  input  logic [FTW_W-1:0]   instr_freq_step,
  input  logic [CYC_W-1:0]   instr_cycles,
  input  logic [STEP_W-1:0]  instr_steps,
  input  logic               abort,
  input  logic [PHASE_W-1:0] phase_error,
  output logic [FTW_W-1:0]   dds_freq,
  output logic               sweep_start,
  output logic               sweep_done,
  output logic               pll_enable,
  output logic               busy
`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
  ,
  output logic               pll_locked
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, PLL_LOCK, PLL_TRACK} state_t;

  localparam logic [1:0] MODE_UP  = 2'd0;
  localparam logic [1:0] MODE_TRI = 2'd2;
  localparam logic [1:0] MODE_PLL = 2'd3;

  localparam int TMR_W = (CYC_W > 32) ? CYC_W : 32;
  localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TRACK_LOAD = TMR_W'(TRACK_DIV - 1);

  // Wide enough that integ + (e <<< KI_SHIFT) can never overflow before clamping.
  localparam int SUM_W = FTW_W + KI_SHIFT + 2;
  localparam logic signed [SUM_W-1:0] I_MAX = {{(SUM_W-FTW_W+1){1'b0}}, {(FTW_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] I_MIN = -I_MAX;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [FTW_W-1:0]          init_q, init_d;
  logic [FTW_W-1:0]          step_q, step_d;
  logic [CYC_W-1:0]          cycles_q, cycles_d;
  logic [STEP_W-1:0]         steps_q, steps_d;
  logic [STEP_W-1:0]         step_cnt_q, step_cnt_d;
  logic                      down_q, down_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [FTW_W-1:0]          dds_q, dds_d;
  logic signed [FTW_W-1:0]   integ_q, integ_d;
  logic                      start_q, start_d;
  logic                      done_q, done_d;

  logic signed [SUM_W-1:0]   e_wide, integ_ext, integ_sum, integ_sat;
  logic [FTW_W-1:0]          p_term;
  logic                      pi_upd;

  assign e_wide    = {{(SUM_W-PHASE_W){phase_error[PHASE_W-1]}}, phase_error};
  assign integ_ext = {{(SUM_W-FTW_W){integ_q[FTW_W-1]}}, integ_q};
  assign integ_sum = integ_ext + (e_wide <<< KI_SHIFT);
  assign integ_sat = (integ_sum > I_MAX) ? I_MAX : ((integ_sum < I_MIN) ? I_MIN : integ_sum);
  assign p_term    = e_wide[FTW_W-1:0] << KP_SHIFT;
  assign pi_upd    = (state_q == PLL_TRACK) && !abort && (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      init_q     <= '0;
      step_q     <= '0;
      cycles_q   <= '0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      down_q     <= 1'b0;
      timer_q    <= '0;
      dds_q      <= '0;
      integ_q    <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      init_q     <= init_d;
      step_q     <= step_d;
      cycles_q   <= cycles_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      down_q     <= down_d;
      timer_q    <= timer_d;
      dds_q      <= dds_d;
      integ_q    <= integ_d;
      start_q    <= start_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    init_d     = init_q;
    step_d     = step_q;
    cycles_d   = cycles_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    down_d     = down_q;
    timer_d    = timer_q;
    dds_d      = dds_q;
    integ_d    = integ_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_valid && !abort) begin
          mode_d     = instr_mode;
          init_d     = instr_init_freq;
          step_d     = instr_freq_step;
          cycles_d   = instr_cycles;
          steps_d    = instr_steps;
          step_cnt_d = '0;
          down_d     = 1'b0;
          dds_d      = instr_init_freq;
          if (instr_mode == MODE_PLL) begin
            state_d = PLL_LOCK;
            integ_d = '0;
            timer_d = LOCK_LOAD;
          end else begin
            state_d = SWEEP;
            start_d = 1'b1;
            timer_d = TMR_W'(instr_cycles);
          end
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          timer_d = TMR_W'(cycles_q);
          if (step_cnt_q < steps_q) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
            if (mode_q == MODE_UP || (mode_q == MODE_TRI && !down_q))
              dds_d = dds_q + step_q;
            else
              dds_d = dds_q - step_q;
          end else if (mode_q == MODE_TRI && !down_q && steps_q != '0) begin
            // Peak already dwelt: the down leg starts with its first step.
            down_d     = 1'b1;
            step_cnt_d = STEP_W'(1);
            dds_d      = dds_q - step_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      PLL_LOCK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = PLL_TRACK;
          timer_d = TRACK_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      PLL_TRACK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pi_upd) begin
          integ_d = integ_sat[FTW_W-1:0];
          dds_d   = init_q + p_term + integ_sat[FTW_W-1:0];
          timer_d = TRACK_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready = (state_q == IDLE) && !abort;
  assign busy        = (state_q != IDLE);
  assign pll_enable  = (state_q == PLL_LOCK) || (state_q == PLL_TRACK);
  assign dds_freq    = dds_q;
  assign sweep_start = start_q;
  assign sweep_done  = done_q;

`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
  logic [PHASE_W:0] pe_abs;
  logic [3:0]       lock_cnt_q;
  logic             locked_q;

  assign pe_abs = e_wide[SUM_W-1] ? (PHASE_W+1)'(-e_wide) : (PHASE_W+1)'(e_wide);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (state_d != PLL_TRACK) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (pi_upd) begin
      if (pe_abs < (PHASE_W+1)'(LOCK_THRESH)) begin
        lock_cnt_q <= (lock_cnt_q == 4'd8) ? 4'd8 : lock_cnt_q + 4'd1;
        locked_q   <= (lock_cnt_q >= 4'd7);
      end else begin
        lock_cnt_q <= '0;
        locked_q   <= 1'b0;
      end
    end
  end

  assign pll_locked = locked_q;
`endif

endmodule

// File: tb/tb_freq_sweeper_multimode.sv
// Directed bench for freq_sweeper_multimode: sweeps, triangle, PI tracking, saturation, abort, reset.
// A second instance with fast timing and KI_SHIFT=16 exercises integrator clamping.
module tb_freq_sweeper_multimode;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, valid_s;
  logic [1:0]  mode;
  logic [31:0] init_f, step_f;
  logic [15:0] cycles;
  logic [7:0]  steps;
  logic        abort;
  logic [15:0] phase, phase_s;

  logic        ready, start, done, pll_en, busy;
  logic [31:0] dds;
  logic        ready_s, start_s, done_s, pll_en_s, busy_s;
  logic [31:0] dds_s;
`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
  logic        locked, locked_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  freq_sweeper_multimode dut (
    .clk(clk), .reset(reset), .instr_valid(valid), .instr_ready(ready),
    .instr_mode(mode), .instr_init_freq(init_f), .instr_freq_step(step_f),
    .instr_cycles(cycles), .instr_steps(steps), .abort(abort), .phase_error(phase),
    .dds_freq(dds), .sweep_start(start), .sweep_done(done), .pll_enable(pll_en),
`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
    .pll_locked(locked),
`endif
    .busy(busy)
  );

  freq_sweeper_multimode #(.KI_SHIFT(16), .LOCK_CYCLES(4), .TRACK_DIV(2)) dut_sat (
    .clk(clk), .reset(reset), .instr_valid(valid_s), .instr_ready(ready_s),
    .instr_mode(mode), .instr_init_freq(init_f), .instr_freq_step(step_f),
    .instr_cycles(cycles), .instr_steps(steps), .abort(abort), .phase_error(phase_s),
    .dds_freq(dds_s), .sweep_start(start_s), .sweep_done(done_s), .pll_enable(pll_en_s),
`ifdef FREQ_SWEEPER_LOCK_DETECT_EN
    .pll_locked(locked_s),
`endif
    .busy(busy_s)
  );

  // Called at a negedge; returns at the middle of the first cycle after acceptance.
  task automatic send(input bit sat, input logic [1:0] m, input logic [31:0] f,
                      input logic [31:0] s, input logic [15:0] c, input logic [7:0] n);
    mode = m; init_f = f; step_f = s; cycles = c; steps = n;
    if (sat) valid_s = 1'b1; else valid = 1'b1;
    #1;
    n_checks++;
    if ((sat ? ready_s : ready) !== 1'b1) begin
      n_fail++; $display("FAIL send_ready: got %b expected 1", sat ? ready_s : ready);
    end
    @(negedge clk);
    valid = 1'b0; valid_s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; valid_s = 1'b0; abort = 1'b0;
    mode = '0; init_f = '0; step_f = '0; cycles = '0; steps = '0; phase = '0; phase_s = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, pll_en, start, done} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 10000", {ready, busy, pll_en, start, done});
    end
    n_checks++;
    if (dds !== 32'h0) begin n_fail++; $display("FAIL reset_dds: got %h expected 00000000", dds); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_up();
    send(1'b0, 2'd0, 32'h1000, 32'h10, 16'd2, 8'd3);
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (dds !== 32'h1000 + 32'h10 * (k / 3)) begin
        n_fail++; $display("FAIL up_dds[%0d]: got %h expected %h", k, dds, 32'h1000 + 32'h10 * (k / 3));
      end
      n_checks++;
      if ({start, done, busy, ready} !== {k == 0, 1'b0, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL up_flags[%0d]: got %b expected %b", k, {start, done, busy, ready}, {k == 0, 3'b010});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, busy, ready, start} !== 4'b1010) begin
      n_fail++; $display("FAIL up_end: got %b expected 1010", {done, busy, ready, start});
    end
    n_checks++;
    if (dds !== 32'h1030) begin n_fail++; $display("FAIL up_hold: got %h expected 00001030", dds); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL up_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_sweep_down_wrap();
    send(1'b0, 2'd1, 32'h8, 32'h10, 16'd0, 8'd1);
    n_checks++;
    if (dds !== 32'h8) begin n_fail++; $display("FAIL dn_first: got %h expected 00000008", dds); end
    @(negedge clk);
    n_checks++;
    if (dds !== 32'hFFFF_FFF8 || done !== 1'b0) begin
      n_fail++; $display("FAIL dn_wrap: got %h/%b expected fffffff8/0", dds, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dn_done: got %b%b expected 10", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_triangle();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'd100, 32'd105, 32'd110, 32'd105, 32'd100};
    send(1'b0, 2'd2, 32'd100, 32'd5, 16'd0, 8'd2);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (dds !== exp_seq[k] || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL tri[%0d]: got %0d/%b%b expected %0d/01", k, dds, done, busy, exp_seq[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || dds !== 32'd100) begin
      n_fail++; $display("FAIL tri_done: got %b/%0d expected 1/100", done, dds);
    end
    @(negedge clk);
  endtask

  task automatic test_single_dwell();
    send(1'b0, 2'd0, 32'h77, 32'h1, 16'd1, 8'd0);
    n_checks++;
    if (dds !== 32'h77 || start !== 1'b1) begin
      n_fail++; $display("FAIL one_first: got %h/%b expected 00000077/1", dds, start);
    end
    @(negedge clk);
    n_checks++;
    if (dds !== 32'h77 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL one_second: got %h/%b%b expected 00000077/01", dds, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || dds !== 32'h77) begin
      n_fail++; $display("FAIL one_done: got %b/%h expected 1/00000077", done, dds);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_sweep();
    send(1'b0, 2'd0, 32'h2000, 32'h1, 16'd3, 8'd9);
    repeat (17) @(negedge clk);
    n_checks++;
    if (dds !== 32'h2004) begin n_fail++; $display("FAIL ab_dwell5: got %h expected 00002004", dds); end
    abort = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, start} !== 3'b000 || dds !== 32'h2004) begin
        n_fail++; $display("FAIL ab_idle[%0d]: got %b/%h expected 000/00002004", k, {busy, done, start}, dds);
      end
    end
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ab_ready_blocked: got %b expected 0", ready); end
    abort = 1'b0;
    send(1'b0, 2'd0, 32'h3000, 32'h1, 16'd0, 8'd0);
    n_checks++;
    if (start !== 1'b1 || dds !== 32'h3000) begin
      n_fail++; $display("FAIL ab_restart: got %b/%h expected 1/00003000", start, dds);
    end
    @(negedge clk);
    @(negedge clk);
    // Abort on the final dwell end: no done pulse.
    send(1'b0, 2'd0, 32'h55, 32'h1, 16'd0, 8'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00 || dds !== 32'h55) begin
      n_fail++; $display("FAIL ab_at_end: got %b/%h expected 00/00000055", {busy, done}, dds);
    end
    @(negedge clk);
  endtask

  task automatic test_pll();
    phase = 16'd4;
    send(1'b0, 2'd3, 32'h1000_0000, 32'h0, 16'd0, 8'd0);
    n_checks++;
    if ({pll_en, busy, ready, start} !== 4'b1100 || dds !== 32'h1000_0000) begin
      n_fail++; $display("FAIL pll_lock: got %b/%h expected 1100/10000000", {pll_en, busy, ready, start}, dds);
    end
    repeat (1039) @(negedge clk);
    n_checks++;
    if (dds !== 32'h1000_0000) begin n_fail++; $display("FAIL pll_pre_upd: got %h expected 10000000", dds); end
    @(negedge clk);
    n_checks++;
    if (dds !== 32'h1000_0024) begin n_fail++; $display("FAIL pll_upd1: got %h expected 10000024", dds); end
    repeat (15) @(negedge clk);
    n_checks++;
    if (dds !== 32'h1000_0024) begin n_fail++; $display("FAIL pll_hold: got %h expected 10000024", dds); end
    @(negedge clk);
    n_checks++;
    if (dds !== 32'h1000_0028 || pll_en !== 1'b1) begin
      n_fail++; $display("FAIL pll_upd2: got %h/%b expected 10000028/1", dds, pll_en);
    end
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({pll_en, busy, done} !== 3'b000 || dds !== 32'h1000_0028) begin
      n_fail++; $display("FAIL pll_abort: got %b/%h expected 000/10000028", {pll_en, busy, done}, dds);
    end
    send(1'b0, 2'd1, 32'h9000, 32'h1, 16'd0, 8'd0);
    n_checks++;
    if (start !== 1'b1 || dds !== 32'h9000) begin
      n_fail++; $display("FAIL pll_next: got %b/%h expected 1/00009000", start, dds);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || start !== 1'b0) begin
      n_fail++; $display("FAIL pll_next_done: got %b%b expected 10", done, start);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    phase_s = 16'h7FFF;
    send(1'b1, 2'd3, 32'h0, 32'h0, 16'd0, 8'd0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (dds_s !== 32'h8002_FFF8) begin n_fail++; $display("FAIL sat_upd1: got %h expected 8002fff8", dds_s); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dds_s !== 32'h8003_FFF7) begin n_fail++; $display("FAIL sat_pos: got %h expected 8003fff7", dds_s); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dds_s !== 32'h8003_FFF7) begin n_fail++; $display("FAIL sat_pos_hold: got %h expected 8003fff7", dds_s); end
    phase_s = 16'h8000;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dds_s !== 32'hFFFB_FFFF) begin n_fail++; $display("FAIL sat_swing: got %h expected fffbffff", dds_s); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dds_s !== 32'h7FFC_0001) begin n_fail++; $display("FAIL sat_neg: got %h expected 7ffc0001", dds_s); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL sat_abort: got %b expected 0", busy_s); end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 2'd0, 32'h300, 32'h1, 16'd0, 8'd5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, ready} !== 2'b01 || dds !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: got %b/%h expected 01/00000000", {busy, ready}, dds);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
        n_fail++; $display("FAIL rst_no_done[%0d]: got %b expected 00", k, {done, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep_up();
    test_sweep_down_wrap();
    test_triangle();
    test_single_dwell();
    test_abort_sweep();
    test_pll();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
